eprisc_iobus_arbiter: RTL and testbench

//  Shares the I/O controller internal peripheral bus (15b addr, 16b wdata, 32b rdata) between two masters:

---
 rtl/eprisc_iobus_arbiter_pkg.sv | 26 ++
 rtl/eprisc_iobus_arbiter_rr_pick.sv | 19 +
 rtl/eprisc_iobus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_eprisc_iobus_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/eprisc_iobus_arbiter_pkg.sv
// Shared definitions for the I/O bus arbiter: state encodings, port indices,
// peripheral address map bases and default bus widths.
package eprisc_iobus_arbiter_pkg;

  typedef enum logic [1:0] {
    S_ARB_IDLE  = 2'd0,
    S_ARB_SETUP = 2'd1,
    S_ARB_WAIT  = 2'd2,
    S_ARB_DONE  = 2'd3
  } arb_state_e;

  localparam int P_ARB_HOST = 0;
  localparam int P_ARB_DMA  = 1;

  localparam int ARB_ADDR_W  = 15;
  localparam int ARB_WDATA_W = 16;
  localparam int ARB_RDATA_W = 32;

  // Base addresses decoded downstream of the arbiter
  localparam logic [ARB_ADDR_W-1:0] BASE_GPIO  = 15'h0000;
  localparam logic [ARB_ADDR_W-1:0] BASE_UART  = 15'h0100;
  localparam logic [ARB_ADDR_W-1:0] BASE_SPI   = 15'h0200;
  localparam logic [ARB_ADDR_W-1:0] BASE_VIDEO = 15'h1000;
  localparam logic [ARB_ADDR_W-1:0] BASE_RAM   = 15'h4000;

endpackage

// File: rtl/eprisc_iobus_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the port that did not win last time is chosen.
module eprisc_iobus_arbiter_rr_pick (
  input  logic [1:0] iReq,
  input  logic       iLast,
  output logic       oPick,
  output logic       oValid
);

  always_comb begin
    oValid = |iReq;
    oPick  = 1'b0;
    case (iReq)
      2'b10:   oPick = 1'b1;
      2'b11:   oPick = ~iLast;
      default: oPick = 1'b0;
    endcase
  end

endmodule

// File: rtl/eprisc_iobus_arbiter.sv
// Two-master round-robin arbiter for the I/O controller peripheral bus.
// Define IOARB_TIMEOUT_EN to add the WAIT-state timeout (oErr, rdata forced to all ones).
module eprisc_iobus_arbiter
  import eprisc_iobus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int WDATA_W   = ARB_WDATA_W,
  parameter int RDATA_W   = ARB_RDATA_W,
  parameter int SETUP_CYC = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic                 iBoardClock,
  input  logic                 iBoardReset,
  input  logic [1:0]           iReq,
  input  logic [1:0]           iReqWrite,
  input  logic [2*ADDR_W-1:0]  iReqAddr,
  input  logic [2*WDATA_W-1:0] iReqData,
  output logic [1:0]           oGrant,
  output logic [1:0]           oAck,
  output logic                 oErr,
  output logic [RDATA_W-1:0]   oRData,
  output logic [ADDR_W-1:0]    oBusAddress,
  output logic [WDATA_W-1:0]   oBusData,
  output logic                 oBusWrite,
  output logic                 oBusEnable,
  input  logic [RDATA_W-1:0]   iBusMISO,
  input  logic                 iBusReady
);

  if (SETUP_CYC < 1 || SETUP_CYC > 7 || TIMEOUT < 1) begin : g_param_check
    $error("eprisc_iobus_arbiter: SETUP_CYC must be 1..7 and TIMEOUT >= 1");
  end

  arb_state_e          state_q, state_d;
  logic                last_q, last_d;
  logic [1:0]          grant_q, grant_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WDATA_W-1:0]  data_q, data_d;
  logic [RDATA_W-1:0]  rdata_q, rdata_d;
  logic [2:0]          setup_cnt_q, setup_cnt_d;
  logic                first_q, first_d;
  logic                pick, pick_valid;

`ifdef IOARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                err_q, err_d;
`endif

  eprisc_iobus_arbiter_rr_pick u_pick (
    .iReq   (iReq),
    .iLast  (last_q),
    .oPick  (pick),
    .oValid (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    setup_cnt_d = setup_cnt_q;
    first_d     = first_q;
`ifdef IOARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_ARB_IDLE: begin
        if (pick_valid) begin
          grant_d[P_ARB_HOST] = ~pick;
          grant_d[P_ARB_DMA]  = pick;
          last_d      = pick;
          write_d     = pick ? iReqWrite[1] : iReqWrite[0];
          addr_d      = pick ? iReqAddr[2*ADDR_W-1:ADDR_W] : iReqAddr[ADDR_W-1:0];
          data_d      = pick ? iReqData[2*WDATA_W-1:WDATA_W] : iReqData[WDATA_W-1:0];
          setup_cnt_d = 3'd0;
`ifdef IOARB_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = S_ARB_SETUP;
        end
      end
      S_ARB_SETUP: begin
        if (setup_cnt_q == 3'(SETUP_CYC - 1)) begin
          first_d = 1'b1;
`ifdef IOARB_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
          state_d = S_ARB_WAIT;
        end else begin
          setup_cnt_d = setup_cnt_q + 3'd1;
        end
      end
      S_ARB_WAIT: begin
        first_d = 1'b0;
        if (iBusReady) begin
          if (!write_q) rdata_d = iBusMISO;
          state_d = S_ARB_DONE;
        end
`ifdef IOARB_TIMEOUT_EN
        // Ready on the last permitted cycle takes priority over the timeout
        else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '1;
          state_d = S_ARB_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      S_ARB_DONE: begin
        grant_d = 2'b00;
        state_d = S_ARB_IDLE;
      end
      default: state_d = S_ARB_IDLE;
    endcase
  end

  always_ff @(posedge iBoardClock or negedge iBoardReset) begin
    if (!iBoardReset) begin
      state_q     <= S_ARB_IDLE;
      last_q      <= 1'b1;
      grant_q     <= 2'b00;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      setup_cnt_q <= 3'd0;
      first_q     <= 1'b0;
`ifdef IOARB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      setup_cnt_q <= setup_cnt_d;
      first_q     <= first_d;
`ifdef IOARB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  // Outputs decode from registered state so they all fall with the async reset
  assign oBusEnable  = (state_q == S_ARB_SETUP) || (state_q == S_ARB_WAIT);
  assign oBusWrite   = (state_q == S_ARB_WAIT) && first_q && write_q;
  assign oBusAddress = oBusEnable ? addr_q : '0;
  assign oBusData    = oBusEnable ? data_q : '0;
  assign oGrant      = grant_q;
  assign oAck        = (state_q == S_ARB_DONE) ? grant_q : 2'b00;
  assign oRData      = rdata_q;
`ifdef IOARB_TIMEOUT_EN
  assign oErr        = (state_q == S_ARB_DONE) && err_q;
`else
  assign oErr        = 1'b0;
`endif

endmodule

// File: tb/tb_eprisc_iobus_arbiter.sv
// Directed self-checking bench for eprisc_iobus_arbiter (default parameters, SETUP_CYC=1).
module tb_eprisc_iobus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_write = 2'b00;
  logic [29:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [31:0] miso = '0;
  logic        ready = 1'b0;
  logic [1:0]  grant, ack;
  logic        err, bus_write, bus_enable;
  logic [31:0] rdata;
  logic [14:0] bus_addr;
  logic [15:0] bus_data;

  int n_vec = 0;
  int n_err = 0;

  eprisc_iobus_arbiter dut (
    .iBoardClock (clk),
    .iBoardReset (rst_n),
    .iReq        (req),
    .iReqWrite   (req_write),
    .iReqAddr    (req_addr),
    .iReqData    (req_data),
    .oGrant      (grant),
    .oAck        (ack),
    .oErr        (err),
    .oRData      (rdata),
    .oBusAddress (bus_addr),
    .oBusData    (bus_data),
    .oBusWrite   (bus_write),
    .oBusEnable  (bus_enable),
    .iBusMISO    (miso),
    .iBusReady   (ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0]  exp_g;
    logic        saw_ack;
    int          lat;

    // Reset values
    repeat (2) tick;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", 32'(bus_addr), 32'h0);
    chk("rst_data", 32'(bus_data), 32'h0);
    chk("rst_wr", 32'(bus_write), 32'h0);
    chk("rst_en", 32'(bus_enable), 32'h0);
    rst_n = 1'b1;
    tick;

    // Port 0 write, ready on third WAIT cycle: ack five cycles after the arbitration cycle
    req = 2'b01; req_write = 2'b01; req_addr = {15'h0000, 15'h0012}; req_data = {16'h0000, 16'hBEEF};
    miso = 32'hDEADBEEF;
    tick;
    chk("t1_setup_grant", 32'(grant), 32'h1);
    chk("t1_setup_en", 32'(bus_enable), 32'h1);
    chk("t1_setup_wr", 32'(bus_write), 32'h0);
    chk("t1_setup_addr", 32'(bus_addr), 32'h0012);
    chk("t1_setup_data", 32'(bus_data), 32'hBEEF);
    req = 2'b00;
    tick;
    chk("t1_wait1_wr", 32'(bus_write), 32'h1);
    chk("t1_wait1_en", 32'(bus_enable), 32'h1);
    tick;
    chk("t1_wait2_wr", 32'(bus_write), 32'h0);
    chk("t1_wait2_ack", 32'(ack), 32'h0);
    tick;
    chk("t1_wait3_wr", 32'(bus_write), 32'h0);
    chk("t1_wait3_en", 32'(bus_enable), 32'h1);
    ready = 1'b1;
    tick;
    chk("t1_done_ack", 32'(ack), 32'h1);
    chk("t1_done_err", 32'(err), 32'h0);
    chk("t1_done_en", 32'(bus_enable), 32'h0);
    chk("t1_done_rdata", rdata, 32'h0);
    ready = 1'b0;
    tick;
    chk("t1_idle_grant", 32'(grant), 32'h0);
    chk("t1_idle_ack", 32'(ack), 32'h0);

    // Port 1 read, ready on first WAIT cycle
    req = 2'b10; req_write = 2'b00; req_addr = {15'h0045, 15'h0000}; miso = 32'h12345678;
    tick;
    chk("t2_setup_grant", 32'(grant), 32'h2);
    chk("t2_setup_addr", 32'(bus_addr), 32'h0045);
    req = 2'b00;
    tick;
    chk("t2_wait_wr", 32'(bus_write), 32'h0);
    ready = 1'b1;
    tick;
    chk("t2_done_ack", 32'(ack), 32'h2);
    chk("t2_done_rdata", rdata, 32'h12345678);
    ready = 1'b0; miso = 32'h0;
    tick;
    chk("t2_idle_rdata", rdata, 32'h12345678);
    chk("t2_idle_ack", 32'(ack), 32'h0);

    // Both ports requesting continuously, ready held high throughout
    req = 2'b11; req_write = 2'b00; req_addr = {15'h0200, 15'h0100}; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      miso = 32'h10000000 | 32'(i);
      tick;
      chk($sformatf("t3_grant%0d", i), 32'(grant), 32'(exp_g));
      chk($sformatf("t3_addr%0d", i), 32'(bus_addr), (i % 2 == 0) ? 32'h0100 : 32'h0200);
      tick;
      chk($sformatf("t3_wait_en%0d", i), 32'(bus_enable), 32'h1);
      tick;
      chk($sformatf("t3_ack%0d", i), 32'(ack), 32'(exp_g));
      chk($sformatf("t3_rdata%0d", i), rdata, 32'h10000000 | 32'(i));
      tick;
      chk($sformatf("t3_idle%0d", i), 32'(grant), 32'h0);
    end
    req = 2'b00; ready = 1'b0;

    // Request and address change during SETUP do not disturb the latched transaction
    req = 2'b01; req_write = 2'b01; req_addr = {15'h0000, 15'h0033}; req_data = {16'h0000, 16'h1234};
    tick;
    chk("t4_setup_addr", 32'(bus_addr), 32'h0033);
    req = 2'b00; req_addr = {15'h0000, 15'h7FFF}; req_data = {16'h0000, 16'hFFFF};
    tick;
    chk("t4_wait_addr", 32'(bus_addr), 32'h0033);
    chk("t4_wait_data", 32'(bus_data), 32'h1234);
    chk("t4_wait_wr", 32'(bus_write), 32'h1);
    ready = 1'b1;
    tick;
    chk("t4_done_ack", 32'(ack), 32'h1);
    chk("t4_done_rdata", rdata, 32'h10000003);
    ready = 1'b0;
    tick;

    // Asynchronous reset in WAIT
    req = 2'b01; req_write = 2'b00; req_addr = {15'h0000, 15'h0055};
    tick;
    req = 2'b00;
    tick;
    chk("t5_wait_en", 32'(bus_enable), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_en", 32'(bus_enable), 32'h0);
    chk("t5_rst_grant", 32'(grant), 32'h0);
    chk("t5_rst_addr", 32'(bus_addr), 32'h0);
    chk("t5_rst_rdata", rdata, 32'h0);
    saw_ack = 1'b0;
    repeat (3) begin
      tick;
      saw_ack = saw_ack | (|ack);
    end
    chk("t5_rst_noack", 32'(saw_ack), 32'h0);
    rst_n = 1'b1;
    req = 2'b11; req_addr = {15'h0200, 15'h0100};
    tick;
    chk("t5_tie_grant", 32'(grant), 32'h1);
    req = 2'b00; ready = 1'b1; miso = 32'hCAFEF00D;
    tick;
    tick;
    chk("t5_done_ack", 32'(ack), 32'h1);
    chk("t5_done_rdata", rdata, 32'hCAFEF00D);
    ready = 1'b0;
    tick;

    // Peripheral never ready
    req = 2'b10; req_write = 2'b00; req_addr = {15'h0045, 15'h0000};
    tick;
    req = 2'b00;
`ifdef IOARB_TIMEOUT_EN
    lat = 0;
    for (int i = 1; i <= 200 && lat == 0; i++) begin
      tick;
      if (|ack) lat = i;
    end
    chk("t6_timeout_lat", 32'(lat), 32'd65);
    chk("t6_timeout_ack", 32'(ack), 32'h2);
    chk("t6_timeout_err", 32'(err), 32'h1);
    chk("t6_timeout_rdata", rdata, 32'hFFFFFFFF);
`else
    lat = 0;
    saw_ack = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick;
      saw_ack = saw_ack | (|ack) | err;
      lat++;
    end
    chk("t6_hang_noack", 32'(saw_ack), 32'h0);
    chk("t6_hang_en", 32'(bus_enable), 32'h1);
    chk("t6_hang_grant", 32'(grant), 32'h2);
`endif
    rst_n = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
